load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Datapath-side initiator for the byte-wide data memory. Accepts one LW/LH/LB/SW/SH/SB
//  request per handshake and serialises it into byte accesses. Big-endian: mem[addr] is the MSB.
//  Loads are assembled and extended; stores are split into bytes. Used by the multi-cycle datapath,
//  which stalls on req_ready/resp_valid.
// PARAMETERS
//  ADDR_W       8  memory byte-address width (256-byte memory)
//  CHECK_ALIGN  1  1: misaligned half/word is an error; 0: misaligned access allowed
// PORTS
//  clk         in   1       rising-edge clock (one clock)
//  rst         in   1       asynchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit can accept (IDLE only)
//  req_write   in   1       1 store, 0 load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads: 1 sign-extend, 0 zero-extend
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data (low bytes used for SB/SH)
//  resp_valid  out  1       one-cycle completion pulse
//  resp_rdata  out  32      extended load data (0 for stores/errors)
//  resp_error  out  1       qualifies resp_valid: illegal size, misaligned, or out of range
//  mem_addr    out  ADDR_W  byte address to memory
//  mem_re      out  1       byte read strobe
//  mem_we      out  1       byte write strobe
//  mem_wdata   out  8       byte to write
//  mem_rdata   in   8       byte read data, combinational from mem_addr (same cycle)
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; req_ready=1; resp_valid=0, resp_error=0, resp_rdata=0;
//    mem_re=mem_we=0, mem_addr=0, mem_wdata=0. A mid-operation reset aborts with no response;
//    any bytes already written stay written.
//  - FSM: IDLE -> ACCESS on an accepted request (req_valid & req_ready) with no error.
//    IDLE -> RESP on an accepted request with an error.
//    ACCESS -> RESP after N byte cycles (N = 1/2/4 for byte/half/word). RESP -> IDLE always.
//  - Registers: request fields are captured on accept; inputs are don't-care afterwards.
//  - Errors (checked at accept):
//    - size 11;
//    - CHECK_ALIGN and half with addr[0]!=0, or word with addr[1:0]!=0;
//    - addr+N-1 >= 2**ADDR_W, or any req_addr bit above ADDR_W-1 set.
//    No mem strobe is issued; resp_error=1 and resp_rdata=0 in RESP.
//  - ACCESS, byte counter k=0..N-1:
//    - mem_addr = base+k.
//    - Load: mem_re=1. Shift register sh <= {sh[23:0],mem_rdata}.
//    - Store: mem_we=1 and mem_wdata = byte (N-1-k) of req_wdata, counted from the LSB,
//      so the MSB goes to the base address.
//  - Strobes are asserted only in ACCESS, never both at once, and exactly N cycles per request.
//  - RESP (one cycle): resp_valid=1.
//    - Load: resp_rdata is the low 8*N bits of sh, extended to 32 bits. Sign extension copies bit
//      8*N-1 of the loaded value. Zero extension fills with 0.
//    - Store: resp_rdata=0.
//    resp_valid, resp_error and resp_rdata are registered and are 0 outside RESP.
//  - Latency: accept at cycle 0; ACCESS at cycles 1..N; resp_valid at cycle N+1; req_ready=1 again
//    at cycle N+2. Error latency: resp_valid at cycle 1.
//  - req_ready=0 in ACCESS/RESP. req_valid held high is accepted again only after returning to
//    IDLE; there is no implicit re-issue.
//  - Address arithmetic is ADDR_W bits with no wrap; wrap is prevented by the range check.
// STRUCTURE
//  - Shared package (lsu_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encodings,
//    function size_to_bytes().
//  - One natural sub-module, load_extend: combinational, (sh, size, signed) -> resp_rdata.
//    Everything else stays in a single FSM + counter + shift register.
// TESTING
//  - Preload mem[0x10..0x13]=0x12,0x34,0x56,0x78. LW 0x10 -> mem_re for 4 cycles at addrs
//    0x10..0x13; resp at cycle 5, rdata=0x12345678, error=0.
//  - Preload mem[0x20]=0x80. LB signed 0x20 -> rdata=0xFFFFFF80. LB unsigned 0x20 -> 0x00000080.
//    Each takes 2 cycles to resp.
//  - SH 0x30, wdata=0xDEADBEEF -> mem_we at 0x30=0xBE, then 0x31=0xEF; resp error=0.
//    Then LH signed 0x30 -> 0xFFFFBEEF.
//  - Error cases, each giving resp_valid at cycle 1, error=1, no strobes:
//    LW 0x11 with CHECK_ALIGN=1; size=11; LW 0xFE (range); addr 0x100 (upper bits set).
//  - Assert rst during the 2nd byte cycle of SW 0x40 (wdata 0xAABBCCDD) -> strobes drop
//    immediately, no resp_valid, req_ready=1. mem[0x40]=0xAA, mem[0x41] unchanged.
//  - req_valid held high for two back-to-back SB -> second accepted at cycle 3; req_ready=0
//    between accepts; exactly 1 mem_we per SB.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Illegal size maps to 1 so range arithmetic stays defined; it is flagged as an error anyway.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_HALF: size_to_bytes = 3'd2;
      SZ_WORD: size_to_bytes = 3'd4;
      default: size_to_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extends the assembled big-endian load value (low 8*N bits of sh) to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] sh,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = {{24{is_signed & sh[7]}}, sh[7:0]};
      SZ_HALF: rdata = {{16{is_signed & sh[15]}}, sh[15:0]};
      SZ_WORD: rdata = sh;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Serialises LW/LH/LB/SW/SH/SB requests into byte accesses on a byte-wide, big-endian memory.
//   state     | meaning
//   ST_IDLE   | ready for a request; errors detected at accept go straight to ST_RESP
//   ST_ACCESS | one byte strobe per cycle, rem_q counts down to the last byte
//   ST_RESP   | one-cycle registered response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e state, state_nxt;

  logic              accept;
  logic [2:0]        req_n;
  logic [32:0]       req_end;
  logic              req_err;

  logic              wr_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;
  logic [1:0]        rem_q;
  logic [1:0]        idx;
  logic [31:0]       sh_q;
  logic [31:0]       sh_nxt;
  logic [31:0]       ext;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_n     = size_to_bytes(req_size);

  // 33-bit end address: any bit at or above ADDR_W means out of range or upper address bits set.
  assign req_end   = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_BAD)
      req_err = 1'b1;
    if (CHECK_ALIGN && (req_size == SZ_HALF) && req_addr[0])
      req_err = 1'b1;
    if (CHECK_ALIGN && (req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
    if (req_end[32:ADDR_W] != '0)
      req_err = 1'b1;
  end

  // rem_q counts down from N-1, so it directly selects the store byte (MSB first).
  assign idx    = last_q - rem_q;
  assign sh_nxt = {sh_q[23:0], mem_rdata};

  load_extend u_load_extend (
    .sh        (sh_nxt),
    .size      (size_q),
    .is_signed (sgn_q),
    .rdata     (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (accept)
          state_nxt = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_addr = base_q + ADDR_W'(idx);
        mem_re   = ~wr_q;
        mem_we   = wr_q;
        if (wr_q)
          mem_wdata = wdata_q[{rem_q, 3'b000} +: 8];
        if (rem_q == 2'd0)
          state_nxt = ST_RESP;
      end
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      base_q     <= '0;
      wdata_q    <= '0;
      last_q     <= '0;
      rem_q      <= '0;
      sh_q       <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;

      if (accept) begin
        wr_q    <= req_write;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        base_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        last_q  <= 2'(req_n - 3'd1);
        rem_q   <= 2'(req_n - 3'd1);
        sh_q    <= '0;
      end

      if (state == ST_ACCESS) begin
        if (rem_q != 2'd0)
          rem_q <= rem_q - 2'd1;
        if (!wr_q)
          sh_q <= sh_nxt;
      end

      // The last load byte is folded in via sh_nxt so the response is registered on entry to RESP.
      if (state_nxt == ST_RESP) begin
        resp_valid <= 1'b1;
        resp_error <= (state == ST_IDLE);
        if ((state == ST_ACCESS) && !wr_q)
          resp_rdata <= ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory model, response scoreboard, strobe tracing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8), .CHECK_ALIGN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0)
        chk("sb_unexpected_resp", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_rdata", resp_rdata, e.rdata);
        chk("sb_error", 32'(resp_error), 32'(e.err));
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request, traces its strobes, latency and ready recovery.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    int nstb;
    bit got;
    n    = exp_err ? 0 : ((sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4);
    lat  = 0;
    nstb = 0;
    got  = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    sb_q.push_back('{rdata: exp_rd, err: exp_err});
    chk({tag, "_ready_at_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        chk({tag, "_strobe_dir"}, {30'd0, mem_re, mem_we}, {30'd0, ~wr, wr});
        chk({tag, "_strobe_addr"}, 32'(mem_addr), (addr + 32'(nstb)) & 32'hFF);
        if (wr && nstb < n)
          chk({tag, "_strobe_wdata"}, 32'(mem_wdata), (wd >> (8 * (n - 1 - nstb))) & 32'hFF);
        nstb++;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(n + 1));
    chk({tag, "_strobe_count"}, 32'(nstb), 32'(n));
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [6:0] rdy_seen;
    int         we_cnt;

    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_error, |resp_rdata}, 32'd0);
    chk("rst_mem_if", {14'd0, mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);

    preload(8'h10, 8'h12);
    preload(8'h11, 8'h34);
    preload(8'h12, 8'h56);
    preload(8'h13, 8'h78);
    preload(8'h20, 8'h80);
    preload(8'hFC, 8'hA1);
    preload(8'hFD, 8'hB2);
    preload(8'hFE, 8'hC3);
    preload(8'hFF, 8'hD4);
    preload(8'h41, 8'h55);
    rst = 1'b0;

    do_req("lw_10",     1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h1234_5678, 1'b0);
    do_req("lb_s_20",   1'b0, 2'b00, 1'b1, 32'h20,  32'h0,        32'hFFFF_FF80, 1'b0);
    do_req("lb_u_20",   1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        32'h0000_0080, 1'b0);
    do_req("sh_30",     1'b1, 2'b01, 1'b0, 32'h30,  32'hDEAD_BEEF, 32'h0,        1'b0);
    chk("mem_30", 32'(mem[8'h30]), 32'hBE);
    chk("mem_31", 32'(mem[8'h31]), 32'hEF);
    do_req("lh_s_30",   1'b0, 2'b01, 1'b1, 32'h30,  32'h0,        32'hFFFF_BEEF, 1'b0);
    do_req("lh_u_30",   1'b0, 2'b01, 1'b0, 32'h30,  32'h0,        32'h0000_BEEF, 1'b0);
    do_req("lh_s_12",   1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h0000_5678, 1'b0);
    do_req("lw_fc",     1'b0, 2'b10, 1'b1, 32'hFC,  32'h0,        32'hA1B2_C3D4, 1'b0);
    do_req("lb_ff",     1'b0, 2'b00, 1'b1, 32'hFF,  32'h0,        32'hFFFF_FFD4, 1'b0);
    do_req("err_align", 1'b0, 2'b10, 1'b0, 32'h11,  32'h0,        32'h0,         1'b1);
    do_req("err_size",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,         1'b1);
    do_req("err_range", 1'b0, 2'b10, 1'b0, 32'hFE,  32'h0,        32'h0,         1'b1);
    do_req("err_upper", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1);
    do_req("err_sh_al", 1'b1, 2'b01, 1'b0, 32'h31,  32'h1234,     32'h0,         1'b1);

    // Back-to-back stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h50;
    req_wdata = 32'h11;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    rdy_seen    = '0;
    rdy_seen[0] = req_ready;
    we_cnt      = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        req_addr  = 32'h51;
        req_wdata = 32'h22;
      end
      if (k == 4)
        req_valid = 1'b0;
      @(negedge clk);
      rdy_seen[k] = req_ready;
      if (mem_we) begin
        we_cnt++;
        chk("b2b_we_addr", 32'(mem_addr), (k == 1) ? 32'h50 : 32'h51);
      end
    end
    chk("b2b_ready_pattern", 32'(rdy_seen), 32'b1001001);
    chk("b2b_we_count", 32'(we_cnt), 32'd2);
    chk("b2b_mem_50", 32'(mem[8'h50]), 32'h11);
    chk("b2b_mem_51", 32'(mem[8'h51]), 32'h22);

    // Reset during the second byte cycle of a word store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h40;
    req_wdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_sw_b0", {23'd0, mem_we, mem_addr}, {23'd0, 1'b1, 8'h40});
    @(negedge clk);
    chk("rst_sw_b1", {23'd0, mem_we, mem_addr}, {23'd0, 1'b1, 8'h41});
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_mem_40", 32'(mem[8'h40]), 32'hAA);
    chk("rst_mem_41", 32'(mem[8'h41]), 32'h55);

    do_req("lw_10_again", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
